// File: rtl/gcid_node_router_if.sv
// Record stream bundle for gcid_node_router.
// The upstream side carries a tagged record in. The downstream side carries the routed record out.
// The master modport drives i_valid, i_gcid_*, i_payload and i_ready (the environment side).
// The slave modport is the router itself.
interface gcid_node_router_if #(
  parameter int GLOBAL_CELL_ID_WIDTH = 4,
  parameter int PAYLOAD_WIDTH        = 128,
  parameter int NODE_ID_WIDTH        = 4
);
  logic                            i_valid;
  logic                            o_ready;
  logic [GLOBAL_CELL_ID_WIDTH-1:0] i_gcid_x;
  logic [GLOBAL_CELL_ID_WIDTH-1:0] i_gcid_y;
  logic [GLOBAL_CELL_ID_WIDTH-1:0] i_gcid_z;
  logic [PAYLOAD_WIDTH-1:0]        i_payload;
  logic                            o_valid;
  logic                            i_ready;
  logic [PAYLOAD_WIDTH-1:0]        o_payload;
  logic [NODE_ID_WIDTH-1:0]        o_dest_node;
  logic                            o_is_local;

  modport master (
    output i_valid, i_gcid_x, i_gcid_y, i_gcid_z, i_payload, i_ready,
    input  o_ready, o_valid, o_payload, o_dest_node, o_is_local
  );

  modport slave (
    input  i_valid, i_gcid_x, i_gcid_y, i_gcid_z, i_payload, i_ready,
    output o_ready, o_valid, o_payload, o_dest_node, o_is_local
  );
endinterface

// File: rtl/gcid_node_router.sv
// Maps a 3D global cell ID to its owning FPGA node.
// Records whose cell ID lies outside the grid are dropped.
// Every other record is tagged local or remote and queued in a small FWFT FIFO.
// Stage 1 registers the per-axis node coordinates and the range check.
// Stage 2 folds the coordinates into a node ID and writes the FIFO.
module gcid_node_router #(
  parameter int DIM_X                = 6,
  parameter int DIM_Y                = 6,
  parameter int DIM_Z                = 6,
  parameter int NODE_X               = 2,
  parameter int NODE_Y               = 2,
  parameter int NODE_Z               = 1,
  parameter int MY_NODE_ID           = 0,
  parameter int NODE_ID_WIDTH        = 4,
  parameter int PAYLOAD_WIDTH        = 128,
  parameter int FIFO_DEPTH           = 4,
  parameter int CNT_WIDTH            = 16,
  parameter int GLOBAL_CELL_ID_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  gcid_node_router_if.slave    bus,
  output logic [CNT_WIDTH-1:0] o_local_cnt,
  output logic [CNT_WIDTH-1:0] o_remote_cnt,
  output logic                 o_range_err
);

  localparam int CPN_X   = DIM_X / NODE_X;
  localparam int CPN_Y   = DIM_Y / NODE_Y;
  localparam int CPN_Z   = DIM_Z / NODE_Z;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int ENTRY_W = PAYLOAD_WIDTH + NODE_ID_WIDTH + 1;

  typedef logic [NODE_ID_WIDTH-1:0] node_t;
  typedef logic [ENTRY_W-1:0]       entry_t;

  logic                     rst_q, rst_d;
  logic                     s1_valid_q, s1_valid_d;
  logic                     s1_bad_q, s1_bad_d;
  node_t                    s1_nx_q, s1_nx_d;
  node_t                    s1_ny_q, s1_ny_d;
  node_t                    s1_nz_q, s1_nz_d;
  logic [PAYLOAD_WIDTH-1:0] s1_payload_q, s1_payload_d;
  entry_t                   mem_q [FIFO_DEPTH];
  entry_t                   mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]           count_q, count_d;
  logic [CNT_WIDTH-1:0]     local_cnt_q, local_cnt_d;
  logic [CNT_WIDTH-1:0]     remote_cnt_q, remote_cnt_d;
  logic                     range_err_q, range_err_d;

  logic                     accept;
  logic                     push;
  logic                     pop;
  logic [PTR_W+1:0]         occupancy;
  node_t                    s2_node;
  logic                     s2_is_local;

  // Handshake and stage-2 node fold.
  // Records sitting in stage 1 count against FIFO space, so a push can never find the FIFO full.
  always_comb begin
    occupancy   = (PTR_W+2)'(count_q) + (PTR_W+2)'(s1_valid_q);
    bus.o_ready = !rst_q && (occupancy <= (PTR_W+2)'(FIFO_DEPTH - 1));
    accept      = bus.i_valid && bus.o_ready;
    s2_node     = node_t'(32'(s1_nx_q) + 32'(NODE_X) * (32'(s1_ny_q) + 32'(NODE_Y) * 32'(s1_nz_q)));
    s2_is_local = (s2_node == node_t'(MY_NODE_ID));
    push        = s1_valid_q && !s1_bad_q;
    pop         = (count_q != '0) && bus.i_ready;
    bus.o_valid = (count_q != '0);
    {bus.o_payload, bus.o_dest_node, bus.o_is_local} = mem_q[rd_ptr_q];
    o_local_cnt  = local_cnt_q;
    o_remote_cnt = remote_cnt_q;
    o_range_err  = range_err_q;
  end

  // Next-state logic for stage 1, the FIFO and the statistics.
  always_comb begin
    rst_d        = rst;
    s1_valid_d   = accept;
    s1_bad_d     = s1_bad_q;
    s1_nx_d      = s1_nx_q;
    s1_ny_d      = s1_ny_q;
    s1_nz_d      = s1_nz_q;
    s1_payload_d = s1_payload_q;
    if (accept) begin
      s1_nx_d      = node_t'(32'(bus.i_gcid_x) / 32'(CPN_X));
      s1_ny_d      = node_t'(32'(bus.i_gcid_y) / 32'(CPN_Y));
      s1_nz_d      = node_t'(32'(bus.i_gcid_z) / 32'(CPN_Z));
      s1_bad_d     = (32'(bus.i_gcid_x) >= 32'(DIM_X)) ||
                     (32'(bus.i_gcid_y) >= 32'(DIM_Y)) ||
                     (32'(bus.i_gcid_z) >= 32'(DIM_Z));
      s1_payload_d = bus.i_payload;
    end

    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = {s1_payload_q, s2_node, s2_is_local};
    end
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    local_cnt_d  = local_cnt_q;
    remote_cnt_d = remote_cnt_q;
    if (push && s2_is_local && (local_cnt_q != '1)) begin
      local_cnt_d = local_cnt_q + 1'b1;
    end
    if (push && !s2_is_local && (remote_cnt_q != '1)) begin
      remote_cnt_d = remote_cnt_q + 1'b1;
    end
    range_err_d = range_err_q || (s1_valid_q && s1_bad_q);
  end

  // State registers. FIFO storage and stage-1 data need no reset because their valid bits guard them.
  always_ff @(posedge clk) begin
    rst_q        <= rst_d;
    mem_q        <= mem_d;
    s1_bad_q     <= s1_bad_d;
    s1_nx_q      <= s1_nx_d;
    s1_ny_q      <= s1_ny_d;
    s1_nz_q      <= s1_nz_d;
    s1_payload_q <= s1_payload_d;
    if (rst) begin
      s1_valid_q   <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      local_cnt_q  <= '0;
      remote_cnt_q <= '0;
      range_err_q  <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      local_cnt_q  <= local_cnt_d;
      remote_cnt_q <= remote_cnt_d;
      range_err_q  <= range_err_d;
    end
  end

endmodule

// File: tb/tb_gcid_node_router.sv
// Scoreboard bench for gcid_node_router on a 6x6x6 grid split 2x2x1, with this FPGA as node 0.
// The stimulus process pushes hand-computed expected records when each input is accepted.
// The monitor pops and compares whenever the router hands a record downstream.
module tb_gcid_node_router;
  localparam int PW = 128;
  localparam int NW = 4;
  localparam int GW = 4;
  localparam int CW = 16;

  typedef struct {
    logic [PW-1:0] payload;
    logic [NW-1:0] node;
    logic          is_local;
  } exp_t;

  typedef struct {
    int            x;
    int            y;
    int            z;
    logic [NW-1:0] node;
    logic          is_local;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CW-1:0] local_cnt;
  logic [CW-1:0] remote_cnt;
  logic          range_err;

  exp_t exp_q[$];
  vec_t tbl[8];
  int   tests = 0;
  int   fails = 0;
  bit   track_occ = 1'b0;
  int   max_occ = 0;

  always #5 clk = ~clk;

  gcid_node_router_if #(.GLOBAL_CELL_ID_WIDTH(GW), .PAYLOAD_WIDTH(PW), .NODE_ID_WIDTH(NW)) bus ();

  gcid_node_router #(
    .DIM_X(6), .DIM_Y(6), .DIM_Z(6), .NODE_X(2), .NODE_Y(2), .NODE_Z(1),
    .MY_NODE_ID(0), .NODE_ID_WIDTH(NW), .PAYLOAD_WIDTH(PW), .FIFO_DEPTH(4),
    .CNT_WIDTH(CW), .GLOBAL_CELL_ID_WIDTH(GW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .o_local_cnt(local_cnt),
    .o_remote_cnt(remote_cnt),
    .o_range_err(range_err)
  );

  task automatic checkOutput(input string name, input logic [159:0] act, input logic [159:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic setVec(input vec_t v, input logic [PW-1:0] p);
    bus.i_gcid_x  = GW'(v.x);
    bus.i_gcid_y  = GW'(v.y);
    bus.i_gcid_z  = GW'(v.z);
    bus.i_payload = p;
  endtask

  // Offers one record and waits (bounded) for acceptance. It then returns 1ns after the accepting edge with i_valid still high.
  task automatic applyStimulus(input vec_t v, input logic [PW-1:0] p, input logic bad);
    int waited = 0;
    bus.i_valid = 1'b1;
    setVec(v, p);
    @(negedge clk);
    while (!bus.o_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.o_ready) begin
      tests++;
      fails++;
      $display("[TB] FAIL accept_timeout: o_ready stayed %0b, required 1", bus.o_ready);
      bus.i_valid = 1'b0;
    end else begin
      @(posedge clk);
      if (!bad) exp_q.push_back('{p, v.node, v.is_local});
      #1;
    end
  endtask

  task automatic idle();
    bus.i_valid = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 100) begin
      @(posedge clk);
      w++;
    end
    checkOutput("drain_complete", 160'(exp_q.size()), 160'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("idle_after_drain", 160'(bus.o_valid), 160'(0));
  endtask

  task automatic doReset();
    bus.i_valid = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares each delivered head against the scoreboard and checks that a stalled head holds still.
  initial begin
    bit                 hold_pending = 1'b0;
    logic [PW+NW:0]     hold_val = '0;
    logic [PW+NW:0]     cur;
    exp_t               e;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_pending = 1'b0;
      end else begin
        if (track_occ && exp_q.size() > max_occ) max_occ = exp_q.size();
        cur = {bus.o_payload, bus.o_dest_node, bus.o_is_local};
        if (hold_pending && bus.o_valid) checkOutput("head_hold", 160'(cur), 160'(hold_val));
        if (bus.o_valid && bus.i_ready) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL unexpected_output: got node %0h payload %0h, required no record", bus.o_dest_node, bus.o_payload);
          end else begin
            e = exp_q.pop_front();
            checkOutput("head_payload", 160'(bus.o_payload), 160'(e.payload));
            checkOutput("head_node", 160'(bus.o_dest_node), 160'(e.node));
            checkOutput("head_is_local", 160'(bus.o_is_local), 160'(e.is_local));
          end
        end
        hold_pending = bus.o_valid && !bus.i_ready;
        hold_val     = cur;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time exhausted, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t v;
    int   acc;
    // CPN = 3/3/6: node = x/3 + 2*(y/3)
    tbl[0] = '{0, 0, 0, 4'd0, 1'b1};
    tbl[1] = '{5, 0, 1, 4'd1, 1'b0};
    tbl[2] = '{0, 5, 2, 4'd2, 1'b0};
    tbl[3] = '{5, 5, 5, 4'd3, 1'b0};
    tbl[4] = '{1, 1, 1, 4'd0, 1'b1};
    tbl[5] = '{2, 2, 2, 4'd0, 1'b1};
    tbl[6] = '{3, 0, 4, 4'd1, 1'b0};
    tbl[7] = '{4, 4, 0, 4'd3, 1'b0};

    bus.i_valid   = 1'b0;
    bus.i_ready   = 1'b1;
    bus.i_gcid_x  = '0;
    bus.i_gcid_y  = '0;
    bus.i_gcid_z  = '0;
    bus.i_payload = '0;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_o_valid", 160'(bus.o_valid), 160'(0));
    checkOutput("rst_o_ready", 160'(bus.o_ready), 160'(0));
    checkOutput("rst_local_cnt", 160'(local_cnt), 160'(0));
    checkOutput("rst_remote_cnt", 160'(remote_cnt), 160'(0));
    checkOutput("rst_range_err", 160'(range_err), 160'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // Single local record: two-cycle latency
    v = '{1, 2, 3, 4'd0, 1'b1};
    applyStimulus(v, 128'hA5, 1'b0);
    idle();
    @(posedge clk);
    @(negedge clk);
    checkOutput("lat_o_valid", 160'(bus.o_valid), 160'(1));
    checkOutput("lat_dest_node", 160'(bus.o_dest_node), 160'(0));
    checkOutput("lat_is_local", 160'(bus.o_is_local), 160'(1));
    checkOutput("lat_local_cnt", 160'(local_cnt), 160'(1));
    drain();

    // Back-to-back remote records, no bubble
    doReset();
    v = '{4, 1, 5, 4'd1, 1'b0};
    applyStimulus(v, 128'hB1, 1'b0);
    v = '{2, 5, 0, 4'd2, 1'b0};
    applyStimulus(v, 128'hB2, 1'b0);
    idle();
    @(negedge clk);
    checkOutput("b2b_first_valid", 160'(bus.o_valid), 160'(1));
    checkOutput("b2b_first_node", 160'(bus.o_dest_node), 160'(1));
    @(negedge clk);
    checkOutput("b2b_second_valid", 160'(bus.o_valid), 160'(1));
    checkOutput("b2b_second_node", 160'(bus.o_dest_node), 160'(2));
    drain();
    checkOutput("b2b_remote_cnt", 160'(remote_cnt), 160'(2));
    checkOutput("b2b_local_cnt", 160'(local_cnt), 160'(0));

    // Out-of-range record dropped, sticky error, then a valid record
    doReset();
    v = '{6, 0, 0, 4'd0, 1'b0};
    applyStimulus(v, 128'hC0, 1'b1);
    idle();
    repeat (3) @(negedge clk);
    checkOutput("range_no_output", 160'(bus.o_valid), 160'(0));
    checkOutput("range_err_set", 160'(range_err), 160'(1));
    checkOutput("range_no_count", 160'(local_cnt + remote_cnt), 160'(0));
    @(posedge clk);
    #1;
    v = '{3, 3, 0, 4'd3, 1'b0};
    applyStimulus(v, 128'hC3, 1'b0);
    idle();
    drain();
    checkOutput("range_remote_cnt", 160'(remote_cnt), 160'(1));
    checkOutput("range_err_sticky", 160'(range_err), 160'(1));

    // Backpressure: six offered, exactly four accepted
    doReset();
    bus.i_ready = 1'b0;
    acc = 0;
    bus.i_valid = 1'b1;
    setVec(tbl[0], 128'(32'h400));
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (bus.o_ready && acc < 6) begin
        @(posedge clk);
        exp_q.push_back('{128'(32'h400 + acc), tbl[acc].node, tbl[acc].is_local});
        acc++;
        #1;
        if (acc < 6) setVec(tbl[acc], 128'(32'h400 + acc));
        else bus.i_valid = 1'b0;
      end else begin
        @(posedge clk);
        #1;
      end
    end
    idle();
    @(negedge clk);
    checkOutput("bp_accepted", 160'(acc), 160'(4));
    checkOutput("bp_o_ready_low", 160'(bus.o_ready), 160'(0));
    checkOutput("bp_head_valid", 160'(bus.o_valid), 160'(1));
    @(posedge clk);
    #1 bus.i_ready = 1'b1;
    drain();
    checkOutput("bp_local_cnt", 160'(local_cnt), 160'(1));
    checkOutput("bp_remote_cnt", 160'(remote_cnt), 160'(3));

    // Full FIFO with i_ready toggling and continuous input
    doReset();
    bus.i_ready = 1'b0;
    max_occ = 0;
    track_occ = 1'b1;
    fork
      begin
        for (int i = 0; i < 16; i++) applyStimulus(tbl[i % 8], 128'(32'h500 + i), 1'b0);
        idle();
      end
      begin
        repeat (6) @(posedge clk);
        repeat (60) begin
          @(posedge clk);
          #1 bus.i_ready = ~bus.i_ready;
        end
      end
    join
    bus.i_ready = 1'b1;
    drain();
    track_occ = 1'b0;
    checkOutput("toggle_max_occupancy", 160'(max_occ), 160'(4));
    checkOutput("toggle_local_cnt", 160'(local_cnt), 160'(6));
    checkOutput("toggle_remote_cnt", 160'(remote_cnt), 160'(10));

    // Reset with three entries queued
    doReset();
    v = '{0, 6, 0, 4'd0, 1'b0};
    applyStimulus(v, 128'hD0, 1'b1);
    bus.i_ready = 1'b0;
    for (int i = 1; i < 4; i++) applyStimulus(tbl[i], 128'(32'h600 + i), 1'b0);
    idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("pre_rst_valid", 160'(bus.o_valid), 160'(1));
    checkOutput("pre_rst_remote_cnt", 160'(remote_cnt), 160'(3));
    checkOutput("pre_rst_range_err", 160'(range_err), 160'(1));
    @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    checkOutput("mid_rst_o_valid", 160'(bus.o_valid), 160'(0));
    checkOutput("mid_rst_o_ready", 160'(bus.o_ready), 160'(0));
    checkOutput("mid_rst_remote_cnt", 160'(remote_cnt), 160'(0));
    checkOutput("mid_rst_local_cnt", 160'(local_cnt), 160'(0));
    checkOutput("mid_rst_range_err", 160'(range_err), 160'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    bus.i_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("post_rst_o_ready", 160'(bus.o_ready), 160'(1));
    checkOutput("post_rst_o_valid", 160'(bus.o_valid), 160'(0));

    checkOutput("scoreboard_empty", 160'(exp_q.size()), 160'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gcid_node_router.md
Name: gcid_node_router

Overview:
- Sits directly downstream of the three per-dimension cell-ID-to-global-cell-ID converters (x, y, z).
- Consumes a particle/force record tagged with its 3D global cell ID and computes the owning FPGA node ID.
- Classifies each record as local or remote and drops records whose cell ID is out of range.
- Buffers results in a small first-word-fall-through (FWFT) FIFO toward the inter-FPGA / local-dispatch arbiter, with valid/ready handshakes on both sides.

Parameters:
- DIM_X, 6: global cells in x; same value as DIM of the x converter.
- DIM_Y, 6: global cells in y.
- DIM_Z, 6: global cells in z.
- NODE_X, 2: FPGA nodes in x; DIM_X % NODE_X == 0 is required.
- NODE_Y, 2: FPGA nodes in y; DIM_Y % NODE_Y == 0 is required.
- NODE_Z, 1: FPGA nodes in z; DIM_Z % NODE_Z == 0 is required.
- MY_NODE_ID, 0: node ID of this FPGA.
- NODE_ID_WIDTH, 4: width of the node ID; must hold NODE_X*NODE_Y*NODE_Z-1.
- PAYLOAD_WIDTH, 128: width of the opaque record payload.
- FIFO_DEPTH, 4: output FIFO entries; power of two, at least 2.
- CNT_WIDTH, 16: width of the statistics counters.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_valid  in  1  input record valid
- o_ready  out  1  block can accept an input record
- i_gcid_x  in  GLOBAL_CELL_ID_WIDTH  global cell x
- i_gcid_y  in  GLOBAL_CELL_ID_WIDTH  global cell y
- i_gcid_z  in  GLOBAL_CELL_ID_WIDTH  global cell z
- i_payload  in  PAYLOAD_WIDTH  record payload
- o_valid  out  1  FIFO head valid
- i_ready  in  1  downstream accepts the head
- o_payload  out  PAYLOAD_WIDTH  head payload
- o_dest_node  out  NODE_ID_WIDTH  destination node of the head
- o_is_local  out  1  head destination equals MY_NODE_ID
- o_local_cnt  out  CNT_WIDTH  records classified local
- o_remote_cnt  out  CNT_WIDTH  records classified remote
- o_range_err  out  1  sticky out-of-range flag

Behaviour:
- One clock domain, clk; rst is synchronous and active-high.
- Reset values: o_valid=0, o_ready=0 during the reset cycle, FIFO empty, stage-1 valid=0, counters=0, o_range_err=0. o_payload, o_dest_node and o_is_local are don't-care while o_valid=0.
- Acceptance: a record is accepted on a rising edge where i_valid && o_ready.
- o_ready is combinational from internal state only: o_ready = !rst_q && (fifo_count + s1_valid <= FIFO_DEPTH-1). It never depends on i_valid or i_ready.
- Stage 1, registered at the acceptance edge:
  - Per-dimension cells per node: CPN_X = DIM_X/NODE_X, CPN_Y = DIM_Y/NODE_Y, CPN_Z = DIM_Z/NODE_Z.
  - Node coordinates: nx = gcid_x / CPN_X, and likewise for ny and nz. These are constant divisions.
  - range_bad = (gcid_x >= DIM_X) || (gcid_y >= DIM_Y) || (gcid_z >= DIM_Z).
- Stage 2, at the next edge:
  - node = nx + NODE_X*(ny + NODE_Y*nz), truncated to NODE_ID_WIDTH.
  - is_local = (node == MY_NODE_ID).
  - If range_bad: no FIFO write, o_range_err <= 1 (sticky until rst), no counter change.
  - Otherwise: write {payload, node, is_local} into the FIFO and increment o_local_cnt or o_remote_cnt.
- Counters saturate at all-ones.
- Latency: a record accepted at edge k is presented at the FIFO head (o_valid=1) in the cycle after edge k+1, provided the FIFO was empty.
- Throughput: one record per cycle sustained when i_ready=1.
- FIFO:
  - FWFT; the head is popped on an edge with o_valid && i_ready.
  - Push and pop on the same edge leave the count unchanged.
  - The o_ready rule guarantees a push never finds the FIFO full, so overflow is impossible by construction.
  - Pointers wrap modulo FIFO_DEPTH.
- Output stability: while o_valid && !i_ready, o_payload, o_dest_node and o_is_local hold stable.
- Reset mid-operation: the FIFO contents, the stage-1 record and the counters are discarded. Outputs return to reset values on the next edge.
- A dropped (range_bad) record still occupies the stage-1 slot for one cycle and is counted in the o_ready calculation.

Test Plan (DIM=6/6/6, NODE=2/2/1, MY_NODE_ID=0, i_ready=1 unless stated):
- gcid (1,2,3), payload 0xA5 -> two cycles later o_valid=1, o_dest_node=0, o_is_local=1, o_local_cnt=1.
- gcid (4,1,5) then (2,5,0) back-to-back -> heads node 1 then node 2, both o_is_local=0, o_remote_cnt=2, no bubble between them.
- gcid x=6 -> nothing reaches the output, o_range_err=1 and stays 1. A following valid record (3,3,0) -> node 3, o_remote_cnt=1.
- i_ready=0 while 6 records are offered -> exactly 4 accepted; o_ready drops when count + s1_valid reaches 4; the head holds stable. Releasing i_ready drains the records in order with no loss or duplicate.
- FIFO full with i_ready toggling every cycle and continuous i_valid -> order preserved, count never exceeds 4.
- rst asserted with 3 entries queued -> next cycle o_valid=0, counters=0, o_range_err=0. After rst deasserts, o_ready=1.
